// File: rtl/turn_scheduler.sv
// Memory-card game round sequencer: takes card picks, compares pairs, keeps
// scores and hands the turn over on mismatch or idle timeout.
module turn_scheduler #(
    parameter int N_CARDS        = 16,
    parameter int SYM_W          = 3,
    parameter int TIMEOUT_CYCLES = 750_000_000,
    parameter int SHOW_CYCLES    = 50_000_000,
    localparam int IDX_W         = $clog2(N_CARDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sel_valid,
    input  logic [IDX_W-1:0]   sel_idx,
    output logic [IDX_W-1:0]   sym_rd_addr,
    input  logic [SYM_W-1:0]   sym_rd_data,
    output logic [N_CARDS-1:0] faceup_mask,
    output logic [N_CARDS-1:0] matched_mask,
    output logic               cur_player,
    output logic [1:0]         cartas_seleccionadas,
    output logic [3:0]         score_p1,
    output logic [3:0]         score_p2,
    output logic [31:0]        turn_timer,
    output logic               game_over,
    output logic [1:0]         winner
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FIRST, S_WAIT_SECOND, S_COMPARE, S_SHOW, S_END
    } state_t;

    localparam logic [3:0]  HALF     = 4'(N_CARDS / 2);
    localparam logic [31:0] TIMEOUT  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] SHOW_LEN = 32'(SHOW_CYCLES);

    state_t             state_q, state_d;
    logic [N_CARDS-1:0] faceup_q, faceup_d, matched_q, matched_d;
    logic               cur_player_q, cur_player_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [3:0]         score_p1_q, score_p1_d, score_p2_q, score_p2_d;
    logic [31:0]        timer_q, timer_d, show_q, show_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;
    logic [SYM_W-1:0]   sym1_q, sym1_d, sym2_q, sym2_d;
    logic [IDX_W-1:0]   idx1_q, idx1_d, idx2_q, idx2_d;

    logic       in_wait, pick_ok, timeout, match, all_done;
    logic [3:0] score_p1_inc, score_p2_inc;

    assign sym_rd_addr = sel_idx;

    always_comb begin
        in_wait = (state_q == S_WAIT_FIRST) || (state_q == S_WAIT_SECOND);
        pick_ok = in_wait && sel_valid && (32'(sel_idx) < 32'(N_CARDS))
                  && !matched_q[sel_idx] && !faceup_q[sel_idx]
                  && !((state_q == S_WAIT_SECOND) && (sel_idx == idx1_q));
        // an accepted pick beats a timeout landing in the same cycle
        timeout = in_wait && !pick_ok && (timer_q <= 32'd1);
        match   = (sym1_q == sym2_q);
        score_p1_inc = score_p1_q;
        score_p2_inc = score_p2_q;
        if (!cur_player_q) begin
            if (score_p1_q < HALF) score_p1_inc = score_p1_q + 4'd1;
        end else begin
            if (score_p2_q < HALF) score_p2_inc = score_p2_q + 4'd1;
        end
        all_done = (5'(score_p1_inc) + 5'(score_p2_inc)) == 5'(HALF);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            faceup_q     <= '0;
            matched_q    <= '0;
            cur_player_q <= 1'b0;
            cnt_q        <= 2'd0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            timer_q      <= TIMEOUT;
            show_q       <= 32'd0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            sym1_q       <= '0;
            sym2_q       <= '0;
            idx1_q       <= '0;
            idx2_q       <= '0;
        end else begin
            state_q      <= state_d;
            faceup_q     <= faceup_d;
            matched_q    <= matched_d;
            cur_player_q <= cur_player_d;
            cnt_q        <= cnt_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            timer_q      <= timer_d;
            show_q       <= show_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            sym1_q       <= sym1_d;
            sym2_q       <= sym2_d;
            idx1_q       <= idx1_d;
            idx2_q       <= idx2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_END: if (start) state_d = S_WAIT_FIRST;
            S_WAIT_FIRST:  if (pick_ok) state_d = S_WAIT_SECOND;
            S_WAIT_SECOND: begin
                if (pick_ok)      state_d = S_COMPARE;
                else if (timeout) state_d = S_WAIT_FIRST;
            end
            S_COMPARE:     state_d = match ? (all_done ? S_END : S_WAIT_FIRST) : S_SHOW;
            S_SHOW:        if (show_q <= 32'd1) state_d = S_WAIT_FIRST;
            default:       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        faceup_d     = faceup_q;
        matched_d    = matched_q;
        cur_player_d = cur_player_q;
        cnt_d        = cnt_q;
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        timer_d      = timer_q;
        show_d       = show_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        sym1_d       = sym1_q;
        sym2_d       = sym2_q;
        idx1_d       = idx1_q;
        idx2_d       = idx2_q;
        case (state_q)
            S_IDLE, S_END: if (start) begin
                faceup_d     = '0;
                matched_d    = '0;
                score_p1_d   = 4'd0;
                score_p2_d   = 4'd0;
                cur_player_d = 1'b0;
                cnt_d        = 2'd0;
                timer_d      = TIMEOUT;
                game_over_d  = 1'b0;
                winner_d     = 2'b00;
            end
            S_WAIT_FIRST, S_WAIT_SECOND: begin
                if (pick_ok) begin
                    faceup_d[sel_idx] = 1'b1;
                    if (state_q == S_WAIT_FIRST) begin
                        sym1_d = sym_rd_data;
                        idx1_d = sel_idx;
                        cnt_d  = 2'd1;
                    end else begin
                        sym2_d = sym_rd_data;
                        idx2_d = sel_idx;
                        cnt_d  = 2'd2;
                    end
                end else if (timeout) begin
                    faceup_d     = '0;
                    cnt_d        = 2'd0;
                    cur_player_d = ~cur_player_q;
                    timer_d      = TIMEOUT;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_COMPARE: begin
                if (match) begin
                    matched_d[idx1_q] = 1'b1;
                    matched_d[idx2_q] = 1'b1;
                    faceup_d[idx1_q]  = 1'b0;
                    faceup_d[idx2_q]  = 1'b0;
                    score_p1_d        = score_p1_inc;
                    score_p2_d        = score_p2_inc;
                    cnt_d             = 2'd0;
                    timer_d           = TIMEOUT;
                    if (all_done) begin
                        game_over_d = 1'b1;
                        if (score_p1_inc > score_p2_inc)      winner_d = 2'b01;
                        else if (score_p2_inc > score_p1_inc) winner_d = 2'b10;
                        else                                  winner_d = 2'b11;
                    end
                end else begin
                    show_d = SHOW_LEN;
                end
            end
            S_SHOW: begin
                if (show_q <= 32'd1) begin
                    faceup_d     = '0;
                    cnt_d        = 2'd0;
                    cur_player_d = ~cur_player_q;
                    timer_d      = TIMEOUT;
                end else begin
                    show_d = show_q - 32'd1;
                end
            end
            default: ;
        endcase
    end

    assign faceup_mask          = faceup_q;
    assign matched_mask         = matched_q;
    assign cur_player           = cur_player_q;
    assign cartas_seleccionadas = cnt_q;
    assign score_p1             = score_p1_q;
    assign score_p2             = score_p2_q;
    assign turn_timer           = timer_q;
    assign game_over            = game_over_q;
    assign winner               = winner_q;
endmodule

// File: tb/tb_turn_scheduler.sv
// Scoreboard bench for turn_scheduler: directed game scenarios plus random
// picks, checked every cycle against a pick-list reference model.
module tb_turn_scheduler;
    localparam int N  = 16;
    localparam int TO = 20;
    localparam int SH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sel_valid = 1'b0;
    logic [3:0]  sel_idx = 4'd0;
    logic [3:0]  sym_rd_addr;
    logic [2:0]  sym_rd_data;
    logic [15:0] faceup_mask, matched_mask;
    logic        cur_player, game_over;
    logic [1:0]  cartas_seleccionadas, winner;
    logic [3:0]  score_p1, score_p2;
    logic [31:0] turn_timer;

    always #5 clk = ~clk;
    assign sym_rd_data = sym_rd_addr[2:0];

    turn_scheduler #(.N_CARDS(N), .SYM_W(3), .TIMEOUT_CYCLES(TO), .SHOW_CYCLES(SH)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .sym_rd_addr(sym_rd_addr), .sym_rd_data(sym_rd_data),
        .faceup_mask(faceup_mask), .matched_mask(matched_mask), .cur_player(cur_player),
        .cartas_seleccionadas(cartas_seleccionadas), .score_p1(score_p1), .score_p2(score_p2),
        .turn_timer(turn_timer), .game_over(game_over), .winner(winner));

    typedef struct {
        logic [15:0] faceup, matched;
        logic        player;
        logic [1:0]  cnt;
        logic [3:0]  s1, s2;
        logic [31:0] timer;
        logic        over;
        logic [1:0]  win;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: a turn is the list of cards picked so far.
    localparam int P_IDLE = 0, P_PLAY = 1, P_CMP = 2, P_SHOW = 3, P_END = 4;
    int          m_phase = P_IDLE;
    int          m_picks[$];
    logic [15:0] m_matched = '0;
    int          m_p1 = 0, m_p2 = 0, m_timer = TO, m_show = 0;
    bit          m_player = 0, m_over = 0;

    function automatic int sym(input int i);
        return i % 8;
    endfunction

    function automatic logic [15:0] picks_mask();
        logic [15:0] m = '0;
        foreach (m_picks[k]) m[m_picks[k]] = 1'b1;
        return m;
    endfunction

    task automatic end_turn(input bit toggle);
        m_picks.delete();
        if (toggle) m_player = ~m_player;
        m_timer = TO;
        m_phase = P_PLAY;
    endtask

    task automatic model_step(input bit r, input bit st, input bit sv, input int idx);
        bit legal;
        if (!r) begin
            m_phase = P_IDLE; m_picks.delete(); m_matched = '0;
            m_p1 = 0; m_p2 = 0; m_timer = TO; m_player = 0; m_over = 0;
            return;
        end
        case (m_phase)
            P_IDLE, P_END: if (st) begin
                m_matched = '0; m_p1 = 0; m_p2 = 0; m_over = 0; m_player = 0;
                end_turn(0);
            end
            P_PLAY: begin
                legal = sv && idx < N && !m_matched[idx] && !(idx inside {m_picks});
                if (legal) begin
                    m_picks.push_back(idx);
                    if (m_picks.size() == 2) m_phase = P_CMP;
                end else if (m_timer == 1) end_turn(1);
                else m_timer--;
            end
            P_CMP: begin
                if (sym(m_picks[0]) == sym(m_picks[1])) begin
                    m_matched[m_picks[0]] = 1'b1;
                    m_matched[m_picks[1]] = 1'b1;
                    if (!m_player) m_p1 = (m_p1 < N/2) ? m_p1 + 1 : m_p1;
                    else           m_p2 = (m_p2 < N/2) ? m_p2 + 1 : m_p2;
                    end_turn(0);
                    if (m_p1 + m_p2 == N/2) begin m_phase = P_END; m_over = 1; end
                end else begin
                    m_show = SH; m_phase = P_SHOW;
                end
            end
            P_SHOW: if (m_show == 1) end_turn(1); else m_show--;
            default: ;
        endcase
    endtask

    task automatic push_expected();
        exp_t e;
        e.faceup  = picks_mask();
        e.matched = m_matched;
        e.player  = m_player;
        e.cnt     = 2'(m_picks.size());
        e.s1      = 4'(m_p1);
        e.s2      = 4'(m_p2);
        e.timer   = 32'(m_timer);
        e.over    = m_over;
        e.win     = !m_over ? 2'b00 : (m_p1 > m_p2) ? 2'b01 : (m_p2 > m_p1) ? 2'b10 : 2'b11;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit r, input bit st, input bit sv, input int idx);
        @(negedge clk);
        rst = r; start = st; sel_valid = sv; sel_idx = 4'(idx);
        model_step(r, st, sv, idx);
        push_expected();
        #1 check("sym_rd_addr", 32'(sym_rd_addr), 32'(idx & 15));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0);
    endtask

    task automatic pair(input int a, input int b);
        cycle(1, 0, 1, a); cycle(1, 0, 1, b); idle(1);
    endtask

    task automatic settle();
        @(posedge clk); #3;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("faceup_mask", 32'(faceup_mask), 32'(e.faceup));
                check("matched_mask", 32'(matched_mask), 32'(e.matched));
                check("cur_player", 32'(cur_player), 32'(e.player));
                check("cartas", 32'(cartas_seleccionadas), 32'(e.cnt));
                check("score_p1", 32'(score_p1), 32'(e.s1));
                check("score_p2", 32'(score_p2), 32'(e.s2));
                check("turn_timer", turn_timer, e.timer);
                check("game_over", 32'(game_over), 32'(e.over));
                check("winner", 32'(winner), 32'(e.win));
            end
        end
    end

    initial begin : driver
        int guard;
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        cycle(1, 0, 1, 5);              // pick in IDLE is ignored
        cycle(1, 1, 0, 0);
        settle();
        check("start_timer", turn_timer, 32'd20);
        check("start_player", 32'(cur_player), 32'd0);

        pair(3, 11);
        settle();
        check("match_matched", 32'(matched_mask), 32'h0808);
        check("match_score_p1", 32'(score_p1), 32'd1);
        check("match_faceup", 32'(faceup_mask), 32'd0);

        cycle(1, 0, 1, 2); cycle(1, 0, 1, 5); idle(4);
        settle();
        check("show_faceup", 32'(faceup_mask), 32'h0024);
        idle(1);
        settle();
        check("show_end_faceup", 32'(faceup_mask), 32'd0);
        check("show_end_player", 32'(cur_player), 32'd1);

        cycle(1, 0, 1, 0); idle(20);
        settle();
        check("timeout_faceup", 32'(faceup_mask), 32'd0);
        check("timeout_player", 32'(cur_player), 32'd0);

        cycle(1, 0, 1, 3); cycle(1, 0, 1, 4); cycle(1, 0, 1, 4);
        settle();
        check("illegal_cnt", 32'(cartas_seleccionadas), 32'd1);
        check("illegal_faceup", 32'(faceup_mask), 32'h0010);
        check("illegal_timer", turn_timer, 32'd18);

        guard = 0;
        while (m_timer != 1 && guard < 100) begin idle(1); guard++; end
        cycle(1, 0, 1, 7);
        settle();
        check("edge_pick_cnt", 32'(cartas_seleccionadas), 32'd2);
        idle(6);

        cycle(0, 0, 0, 0); cycle(1, 1, 0, 0);
        for (int p = 0; p < 5; p++) pair(p, p + 8);
        pair(5, 6); idle(4);
        for (int p = 5; p < 8; p++) pair(p, p + 8);
        settle();
        check("game1_over", 32'(game_over), 32'd1);
        check("game1_winner", 32'(winner), 32'h1);

        cycle(1, 1, 0, 0);
        for (int p = 0; p < 4; p++) pair(p, p + 8);
        pair(4, 5); idle(4);
        for (int p = 4; p < 8; p++) pair(p, p + 8);
        settle();
        check("game2_winner", 32'(winner), 32'h3);

        cycle(1, 1, 0, 0); pair(1, 2); idle(1);
        cycle(0, 0, 0, 0);
        settle();
        check("rst_faceup", 32'(faceup_mask), 32'd0);
        check("rst_cnt", 32'(cartas_seleccionadas), 32'd0);
        check("rst_timer", turn_timer, 32'd20);

        cycle(1, 1, 0, 0);
        for (int i = 0; i < 4000; i++)
            cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)));

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        #3 check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Sequences one round of the memory-card game.
- Arbitrates the shared card board between the two players: accepts card picks, reads card symbols from the board symbol store, compares pairs, updates per-player scores, and hands the turn over on mismatch or timeout.
- Sits between the input/debounce logic and the display FSM.
- Its cartas_seleccionadas, cur_player, score and game-over outputs drive the display FSM's state sequencing.

Parameters:
- N_CARDS, 16: cards on board; must be even; number of pairs = N_CARDS/2.
- SYM_W, 3: symbol code width.
- TIMEOUT_CYCLES, 750_000_000: cycles a player may idle in a turn before the turn is forfeited (15 s at 50 MHz).
- SHOW_CYCLES, 50_000_000: cycles a mismatched pair stays face-up before being hidden.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new game from IDLE or END.
- sel_valid  in  1  one-cycle pulse; a card pick is presented on sel_idx.
- sel_idx  in  $clog2(N_CARDS)  picked card index.
- sym_rd_addr  out  $clog2(N_CARDS)  symbol-store read address; always equals sel_idx (combinational pass-through).
- sym_rd_data  in  SYM_W  symbol at sym_rd_addr; combinational read, valid in the same cycle.
- faceup_mask  out  N_CARDS  cards currently revealed but not matched.
- matched_mask  out  N_CARDS  cards removed by a successful match.
- cur_player  out  1  0 = player 1, 1 = player 2.
- cartas_seleccionadas  out  2  cards picked in the current turn: 0, 1 or 2.
- score_p1  out  4  pairs won by player 1.
- score_p2  out  4  pairs won by player 2.
- turn_timer  out  32  cycles remaining in the current turn.
- game_over  out  1  high while in END.
- winner  out  2  valid when game_over: 01 = player 1, 10 = player 2, 11 = tie; 00 otherwise.

Behaviour:
- Reset (rst=0 at a clock edge): state = IDLE.
  - All masks, scores, cartas_seleccionadas, cur_player, game_over and winner = 0.
  - turn_timer = TIMEOUT_CYCLES.
  - Reset takes priority over every other input, in every state, including mid-SHOW.
- IDLE: ignore sel_valid. On start:
  - clear masks and scores; cur_player = 0; reload timer; go to WAIT_FIRST.
- WAIT_FIRST: a pick is accepted only if sel_valid=1, sel_idx < N_CARDS, and the card is not matched and not face-up. On accept:
  - latch sym_rd_data into sym1 and sel_idx into idx1;
  - set faceup bit; cartas_seleccionadas = 1; go to WAIT_SECOND.
  - Rejected picks cause no state change.
- WAIT_SECOND: same acceptance rules; additionally sel_idx must differ from idx1. On accept:
  - latch sym2 and idx2; set faceup bit; cartas_seleccionadas = 2; go to COMPARE.
- Turn timer, in WAIT_FIRST and WAIT_SECOND:
  - decrements by 1 each cycle without an accepted pick.
  - An accepted pick does not reload the timer; it reloads only on turn start.
  - When turn_timer reaches 0 before a pick is accepted: clear faceup_mask, cartas_seleccionadas = 0, toggle cur_player, reload timer, go to WAIT_FIRST. No score change.
  - A pick accepted in the same cycle the timer would reach 0 wins: the pick is taken and the timeout is not.
- COMPARE, exactly 1 cycle:
  - Match (sym1 == sym2):
    - set matched bits idx1 and idx2, clear their faceup bits;
    - increment the current player's score (saturating at N_CARDS/2);
    - cartas_seleccionadas = 0; same player keeps the turn; reload timer.
    - If score_p1 + score_p2 after the increment == N_CARDS/2, go to END; else go to WAIT_FIRST.
  - Mismatch: load the show counter with SHOW_CYCLES and go to SHOW.
- SHOW: the show counter decrements each cycle; sel_valid is ignored. At 0:
  - clear faceup_mask; cartas_seleccionadas = 0; toggle cur_player; reload timer; go to WAIT_FIRST.
- END:
  - game_over = 1.
  - winner = 01 if score_p1 > score_p2, 10 if score_p2 > score_p1, 11 if equal.
  - Scores and matched_mask hold.
  - start behaves as in IDLE and clears game_over and winner.
- start while a game is in progress (WAIT_*, COMPARE, SHOW) is ignored.
- All outputs are registered except sym_rd_addr.

Test Plan:
Common setup: N_CARDS=16, TIMEOUT_CYCLES=20, SHOW_CYCLES=4; symbol store holds sym(i) = i mod 8, so cards i and i+8 form a pair.
- Reset and start: hold rst=0 for 2 cycles, release, pulse start.
  - Expect all outputs 0, turn_timer=20, cur_player=0, WAIT_FIRST.
- Match: pick 3, then pick 11.
  - One cycle after the second pick: matched_mask=0x0808, score_p1=1, cur_player=0, faceup_mask=0, cartas_seleccionadas=0.
- Mismatch: pick 2, then pick 5.
  - faceup_mask=0x0024 for exactly 4 cycles of SHOW, then 0.
  - cur_player=1; score_p1 and score_p2 unchanged.
- Illegal picks: pick an already-matched card (3), sel_idx=16 if the port is widened, and the same card twice.
  - No mask, count or state change; the turn timer keeps decrementing.
- Timeout: pick 0, then idle 20 cycles.
  - faceup_mask=0, cur_player toggles, no score change.
  - Picking on the cycle the timer reaches 0 takes the pick instead of timing out.
- Full game: player 1 matches pairs 0–4 and player 2 matches pairs 5–7.
  - game_over=1, winner=01.
  - Repeat with 4/4 split: winner=11.
  - Assert rst=0 mid-SHOW: next cycle IDLE with everything cleared.
